// File: rtl/elliptic_curve_structs.sv
// rtl/elliptic_curve_structs.sv - shared curve types plus field-multiplier FSM state and default width
package elliptic_curve_structs;

  localparam int FIELD_WIDTH = 256;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mod_mult_state_t;

  typedef struct packed {
    logic [FIELD_WIDTH-1:0] x;
    logic [FIELD_WIDTH-1:0] y;
  } curve_point_t;

endpackage

// File: rtl/mod_mult_step.sv
// rtl/mod_mult_step.sv - one double-and-add step of interleaved modular multiplication
module mod_mult_step #(
  parameter int WIDTH = 256
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] p,
  input  logic             b_bit,
  output logic [WIDTH-1:0] acc_next
);

  logic [WIDTH:0] d_raw;
  logic [WIDTH:0] d_red;
  logic [WIDTH:0] s_raw;
  logic [WIDTH:0] s_red;

  // acc < p and a < p keep both sums below 2p, so one subtract each suffices
  always_comb begin
    d_raw    = {acc, 1'b0};
    d_red    = (d_raw >= {1'b0, p}) ? d_raw - {1'b0, p} : d_raw;
    s_raw    = d_red + (b_bit ? {1'b0, a} : {(WIDTH+1){1'b0}});
    s_red    = (s_raw >= {1'b0, p}) ? s_raw - {1'b0, p} : s_raw;
    acc_next = s_red[WIDTH-1:0];
  end

endmodule

// File: rtl/mod_mult_serial.sv
// rtl/mod_mult_serial.sv - bit-serial (a*b) mod p, MSB of b first; MOD_MULT_EARLY_EXIT_EN skips leading zeros of b
module mod_mult_serial
  import elliptic_curve_structs::*;
#(
  parameter  int WIDTH = FIELD_WIDTH,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mod_mult_state_t  state_q, state_d;
  logic [WIDTH-1:0] acc_q, a_q, b_q, p_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_init;
  logic [WIDTH-1:0] acc_next;
  logic             skip_run;

`ifdef MOD_MULT_EARLY_EXIT_EN
  always_comb begin
    cnt_init = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (b[i]) cnt_init = CNT_W'(i);
    end
  end
  assign skip_run = (b == '0);
`else
  assign cnt_init = CNT_W'(WIDTH - 1);
  assign skip_run = 1'b0;
`endif

  mod_mult_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc_q),
    .a        (a_q),
    .p        (p_q),
    .b_bit    (b_q[cnt_q[IDX_W-1:0]]),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = skip_run ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      p_q   <= '0;
      cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            p_q   <= p;
            acc_q <= '0;
            cnt_q <= cnt_init;
          end
        end
        RUN: begin
          acc_q <= acc_next;
          if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign result = acc_q;

endmodule

// File: tb/tb_mod_mult_serial.sv
// tb/tb_mod_mult_serial.sv - scoreboard bench for mod_mult_serial against a big-integer reference
module tb_mod_mult_serial;

  localparam int W = 256;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = '0, b = '0, p = '0;
  logic         in_ready, out_valid, busy;
  logic [W-1:0] result;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  bit hold_mode = 1'b0;
  bit in_done = 1'b0;
  logic [W-1:0] held;

  logic [W-1:0] exp_res[$];
  int           exp_lat[$];
  int           acc_cyc[$];

  mod_mult_serial #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .p         (p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd256();
    logic [W-1:0] r = '0;
    for (int i = 0; i < W / 32; i++) r = {r[W-33:0], 32'($urandom())};
    return r;
  endfunction

  function automatic logic [W-1:0] ref_mod(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [W-1:0] m);
    logic [2*W-1:0] prod;
    logic [2*W-1:0] rem;
    prod = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    rem  = prod % {{W{1'b0}}, m};
    return rem[W-1:0];
  endfunction

  function automatic int ref_lat(input logic [W-1:0] y);
`ifdef MOD_MULT_EARLY_EXIT_EN
    int msb = -1;
    for (int i = 0; i < W; i++) if (y[i]) msb = i;
    return (msb < 0) ? 1 : msb + 2;
`else
    return (y === y) ? W + 1 : W + 1;
`endif
  endfunction

  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [W-1:0] tp,
                       input logic [W-1:0] texp);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: in_ready still %0b after %0d cycles", in_ready, n);
    end
    a = ta;
    b = tb_;
    p = tp;
    in_valid = 1'b1;
    exp_res.push_back(texp);
    exp_lat.push_back(ref_lat(tb_));
    acc_cyc.push_back(cyc + 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = rnd256();
  endtask

  task automatic pulse_garbage(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      in_valid = busy;
      a = rnd256();
      b = rnd256();
      p = rnd256();
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_res.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, busy=%0b", exp_res.size(), busy);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      out_ready = hold_mode ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: first cycle of each out_valid pops the scoreboard; later cycles check hold stability
  always @(negedge clk) begin
    if (!rst_n) begin
      in_done = 1'b0;
    end else begin
      chk("in_ready_vs_busy", W'(in_ready), W'(!busy));
      if (out_valid) begin
        chk("in_ready_in_done", W'(in_ready), '0);
        if (!in_done) begin
          if (exp_res.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_result: got %0h with no operation outstanding", result);
          end else begin
            chk("result", result, exp_res.pop_front());
            chk("latency", W'(cyc - acc_cyc.pop_front() + 1), W'(exp_lat.pop_front()));
          end
          held = result;
          in_done = 1'b1;
        end else begin
          chk("result_stable", result, held);
        end
        if (out_ready) in_done = 1'b0;
      end
    end
  end

  initial begin
    logic [W-1:0] ra, rb, rp, big_b;
    int n;

    repeat (2) @(negedge clk);
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_result", result, '0);
    #2 rst_n = 1'b1;

    issue(W'(6), W'(1), W'(37), W'(6));
    issue(W'(36), W'(36), W'(37), W'(1));
    issue(W'(25), W'(14), W'(37), W'(17));
    issue(W'(5), W'(0), W'(37), W'(0));
    wait_idle();

    // Back-pressure with in_valid noise while the result is held
    hold_mode = 1'b1;
    issue(W'(25), W'(14), W'(37), W'(17));
    n = 0;
    while (!out_valid && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      n_checks++;
      n_fail++;
      $display("FAIL bp_wait_timeout: out_valid=%0b after %0d cycles", out_valid, n);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = rnd256();
      b = rnd256();
      chk("bp_out_valid", W'(out_valid), W'(1));
      chk("bp_in_ready", W'(in_ready), '0);
    end
    in_valid = 1'b0;
    hold_mode = 1'b0;
    wait_idle();

    // Reset in the middle of a long run
    big_b = '0;
    big_b[200] = 1'b1;
    big_b[0] = 1'b1;
    issue(W'(6), big_b, W'(37), ref_mod(W'(6), big_b, W'(37)));
    repeat (100) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", W'(out_valid), '0);
    chk("midrst_busy", W'(busy), '0);
    chk("midrst_in_ready", W'(in_ready), W'(1));
    exp_res.delete();
    exp_lat.delete();
    acc_cyc.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    chk("postrst_in_ready", W'(in_ready), W'(1));
    chk("postrst_out_valid", W'(out_valid), '0);
    issue(W'(6), W'(1), W'(37), W'(6));
    wait_idle();

    for (int k = 0; k < 200; k++) begin
      rp = rnd256() >> $urandom_range(0, 254);
      if (rp < 2) rp = W'(2) + W'($urandom_range(0, 1));
      ra = rnd256() % rp;
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1, 2:    rb = rnd256() >> $urandom_range(0, 255);
        default: rb = rnd256();
      endcase
      issue(ra, rb, rp, ref_mod(ra, rb, rp));
      if ($urandom_range(0, 7) == 0) pulse_garbage(5);
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
